// File: rtl/wb_sram_slave.sv
// Wishbone B4 pipelined SRAM responder with fixed response latency and optional periodic stall.
// Define WB_SRAM_ERR_EN to answer out-of-window addresses with wb_err instead of aliasing.
module wb_sram_slave #(
   parameter int          ADDR_WIDTH   = 12,
   parameter logic [31:0] BASE_ADDR    = 32'h0,
   parameter int          LATENCY      = 1,
   parameter int          STALL_PERIOD = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [3:0]  wb_sel,
   input  logic [31:0] wb_adr,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack,
   output logic        wb_err,
   output logic        wb_stall
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [32:0]           off_ext;
   logic [31:0]           off;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  accept;
   logic                  req_err;

   logic [LATENCY-1:0]    pipe_vld;
   logic [LATENCY-1:0]    pipe_err;
   logic [31:0]           pipe_dat [LATENCY];

   // 33-bit subtract so the borrow flags addresses below the window
   assign off_ext = {1'b0, wb_adr} - {1'b0, BASE_ADDR};
   assign off     = off_ext[31:0];
   assign idx     = off[ADDR_WIDTH+1:2];
   assign accept  = wb_cyc & wb_stb & ~wb_stall;

`ifdef WB_SRAM_ERR_EN
   logic unused_bits;
   assign unused_bits = ^off[1:0];
   assign req_err     = off_ext[32] | ((off >> (ADDR_WIDTH + 2)) != 32'd0);
`else
   logic unused_bits;
   assign unused_bits = ^{off_ext[32], off[31:ADDR_WIDTH+2], off[1:0]};
   assign req_err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (accept && wb_we && !req_err) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel[b]) mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         pipe_err <= '0;
         for (int i = 0; i < LATENCY; i++) pipe_dat[i] <= '0;
      end else begin
         pipe_vld[0] <= accept;
         pipe_err[0] <= accept & req_err;
         pipe_dat[0] <= (accept && !wb_we && !req_err) ? mem[idx] : 32'd0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_err[i] <= pipe_err[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
         end
         // dropping wb_cyc aborts everything still in flight
         if (!wb_cyc) pipe_vld <= '0;
      end
   end

   assign wb_ack   = pipe_vld[LATENCY-1] & ~pipe_err[LATENCY-1];
   assign wb_dat_o = wb_ack ? pipe_dat[LATENCY-1] : 32'd0;

`ifdef WB_SRAM_ERR_EN
   assign wb_err   = pipe_vld[LATENCY-1] & pipe_err[LATENCY-1];
`else
   assign wb_err   = 1'b0;
`endif

   generate
      if (STALL_PERIOD == 0) begin : g_no_stall
         assign wb_stall = 1'b0;
      end else begin : g_stall
         localparam logic [7:0] LAST = 8'(STALL_PERIOD - 1);
         logic [7:0] stall_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                 stall_cnt <= '0;
            else if (stall_cnt == LAST) stall_cnt <= '0;
            else                        stall_cnt <= stall_cnt + 8'd1;
         end

         assign wb_stall = (stall_cnt == LAST);
      end
   endgenerate

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: three instances cover latency 2, latency 3 and periodic stall.
// Build with WB_SRAM_ERR_EN defined to check the error-response expectations.
module tb_wb_sram_slave;

   localparam logic [31:0] BASE_L2 = 32'h1000_0000;
`ifdef WB_SRAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  cyc, stb, we, ack, err, stall;
   logic [3:0]  sel   [3];
   logic [31:0] adr   [3];
   logic [31:0] dat_i [3];
   logic [31:0] dat_o [3];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   wb_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(BASE_L2), .LATENCY(2), .STALL_PERIOD(0)) u_l2 (
      .clk(clk), .rst_n(rst_n), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]),
      .wb_sel(sel[0]), .wb_adr(adr[0]), .wb_dat_i(dat_i[0]), .wb_dat_o(dat_o[0]),
      .wb_ack(ack[0]), .wb_err(err[0]), .wb_stall(stall[0]));

   wb_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .LATENCY(3), .STALL_PERIOD(0)) u_l3 (
      .clk(clk), .rst_n(rst_n), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]),
      .wb_sel(sel[1]), .wb_adr(adr[1]), .wb_dat_i(dat_i[1]), .wb_dat_o(dat_o[1]),
      .wb_ack(ack[1]), .wb_err(err[1]), .wb_stall(stall[1]));

   wb_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .LATENCY(1), .STALL_PERIOD(4)) u_st (
      .clk(clk), .rst_n(rst_n), .wb_cyc(cyc[2]), .wb_stb(stb[2]), .wb_we(we[2]),
      .wb_sel(sel[2]), .wb_adr(adr[2]), .wb_dat_i(dat_i[2]), .wb_dat_o(dat_o[2]),
      .wb_ack(ack[2]), .wb_err(err[2]), .wb_stall(stall[2]));

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] off;
      logic [31:0] dat;
      logic        exp_err;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t vecs [14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Issue one request, then check the response arrives exactly lat edges after the accept edge
   task automatic bus_op(input int k, input int lat, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic exp_err, input logic [31:0] exp_dat, input string name);
      int n;
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; dat_i[k] = d;
      n = 0;
      while (stall[k] && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) begin
         n_total++;
         $display("FAIL %s_stall_wait: stall still high after %0d cycles, required low", name, n);
      end
      tick();
      stb[k] = 1'b0; we[k] = 1'b0;
      for (int i = 1; i < lat; i++) begin
         chk({name, "_early"}, {31'd0, ack[k] | err[k]}, 32'd0);
         tick();
      end
      chk({name, "_ack"}, {31'd0, ack[k]}, {31'd0, ~exp_err});
      chk({name, "_err"}, {31'd0, err[k]}, {31'd0, exp_err});
      chk({name, "_dat"}, dat_o[k], exp_dat);
      tick();
      chk({name, "_single"}, {31'd0, ack[k] | err[k]}, 32'd0);
      cyc[k] = 1'b0;
   endtask

   int acks;
   int next_w;
   bit was_stalled;

   initial begin
      cyc = '0; stb = '0; we = '0;
      for (int k = 0; k < 3; k++) begin
         sel[k] = 4'h0; adr[k] = 32'h0; dat_i[k] = 32'h0;
      end

      vecs[0]  = '{1'b1, 4'hF, 32'h40,       32'hDEADBEEF, 1'b0,   32'h0};
      vecs[1]  = '{1'b0, 4'hF, 32'h40,       32'h0,        1'b0,   32'hDEADBEEF};
      vecs[2]  = '{1'b1, 4'hF, 32'h80,       32'h11223344, 1'b0,   32'h0};
      vecs[3]  = '{1'b1, 4'h2, 32'h80,       32'h0000AA00, 1'b0,   32'h0};
      vecs[4]  = '{1'b0, 4'hF, 32'h80,       32'h0,        1'b0,   32'h1122AA44};
      vecs[5]  = '{1'b1, 4'h9, 32'h80,       32'h55FFFF66, 1'b0,   32'h0};
      vecs[6]  = '{1'b0, 4'h0, 32'h80,       32'h0,        1'b0,   32'h5522AA66};
      vecs[7]  = '{1'b1, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0,   32'h0};
      vecs[8]  = '{1'b0, 4'hF, 32'h4000,     32'h0,        ERR_EN, ERR_EN ? 32'h0 : 32'hCAFEF00D};
      vecs[9]  = '{1'b1, 4'hF, 32'h4000,     32'h12345678, ERR_EN, 32'h0};
      vecs[10] = '{1'b0, 4'hF, 32'h0,        32'h0,        1'b0,   ERR_EN ? 32'hCAFEF00D : 32'h12345678};
      vecs[11] = '{1'b1, 4'hF, 32'h3FFC,     32'h0A0B0C0D, 1'b0,   32'h0};
      vecs[12] = '{1'b0, 4'hF, 32'hFFFFFFFC, 32'h0,        ERR_EN, ERR_EN ? 32'h0 : 32'h0A0B0C0D};
      vecs[13] = '{1'b0, 4'hF, 32'h3FFC,     32'h0,        1'b0,   32'h0A0B0C0D};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_ack%0d", k),   {31'd0, ack[k]},   32'd0);
         chk($sformatf("rst_err%0d", k),   {31'd0, err[k]},   32'd0);
         chk($sformatf("rst_stall%0d", k), {31'd0, stall[k]}, 32'd0);
         chk($sformatf("rst_dat%0d", k),   dat_o[k],          32'd0);
      end
      rst_n = 1'b1;
      tick();

      // table-driven vectors on the latency-2 instance
      for (int i = 0; i < 14; i++) begin
         bus_op(0, 2, vecs[i].we, vecs[i].sel, BASE_L2 + vecs[i].off, vecs[i].dat,
                vecs[i].exp_err, vecs[i].exp_dat, $sformatf("vec%0d", i));
      end

      // latency 3: preset words 0..3, then four back-to-back reads
      for (int i = 0; i < 4; i++)
         bus_op(1, 3, 1'b1, 4'hF, 32'(i * 4), 32'(i + 1), 1'b0, 32'h0, $sformatf("l3_wr%0d", i));
      cyc[1] = 1'b1;
      for (int c = 0; c < 7; c++) begin
         stb[1] = (c < 4);
         adr[1] = 32'(c * 4);
         tick();
         chk($sformatf("b2b_ack%0d", c), {31'd0, ack[1]}, {31'd0, (c >= 2 && c <= 5)});
         chk($sformatf("b2b_dat%0d", c), dat_o[1], (c >= 2 && c <= 5) ? 32'(c - 1) : 32'h0);
      end
      cyc[1] = 1'b0;
      tick();

      // abort: two reads in flight, cyc dropped right after the second accept
      cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h0;
      tick();
      adr[1] = 32'h4;
      tick();
      cyc[1] = 1'b0; stb[1] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("abort_quiet%0d", c), {31'd0, ack[1] | err[1]}, 32'd0);
         tick();
      end
      bus_op(1, 3, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, 32'h3, "after_abort");
      // an aborted write still commits
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h10; dat_i[1] = 32'h77;
      tick();
      cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
      repeat (3) tick();
      bus_op(1, 3, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'h77, "aborted_wr");

      // periodic stall: preset words, align to counter phase 0, then 8 cycles of continuous reads
      for (int i = 0; i < 8; i++)
         bus_op(2, 1, 1'b1, 4'hF, 32'(i * 4), 32'(100 + i), 1'b0, 32'h0, $sformatf("st_wr%0d", i));
      begin
         int n;
         n = 0;
         while (!stall[2] && n < 20) begin
            tick();
            n++;
         end
         if (n >= 20) begin
            n_total++;
            $display("FAIL stall_sync: wb_stall never seen high in %0d cycles", n);
         end
      end
      tick();
      acks = 0; next_w = 0;
      cyc[2] = 1'b1; stb[2] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         adr[2] = 32'(next_w * 4);
         chk($sformatf("stall_c%0d", c), {31'd0, stall[2]}, {31'd0, (c == 3 || c == 7)});
         was_stalled = stall[2];
         tick();
         chk($sformatf("stall_ack%0d", c), {31'd0, ack[2]}, {31'd0, ~was_stalled});
         if (ack[2]) begin
            acks++;
            chk($sformatf("stall_dat%0d", c), dat_o[2], 32'(100 + next_w));
         end
         if (!was_stalled) next_w++;
      end
      cyc[2] = 1'b0; stb[2] = 1'b0;
      chk("stall_ack_count", 32'(acks), 32'd6);
      tick();

      // reset with reads in flight on the latency-3 instance
      cyc[1] = 1'b1; stb[1] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         adr[1] = 32'(c * 4);
         tick();
      end
      stb[1] = 1'b0;
      chk("pre_rst_ack", {31'd0, ack[1]}, 32'd1);
      chk("pre_rst_dat", dat_o[1], 32'h1);
      #2 rst_n = 1'b0;
      cyc[1] = 1'b0;
      #1;
      chk("rst_async_ack", {31'd0, ack[1]}, 32'd0);
      chk("rst_async_dat", dat_o[1], 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("post_rst_quiet%0d", c), {31'd0, ack[1] | err[1]}, 32'd0);
         chk($sformatf("post_rst_stall%0d", c), {31'd0, stall[2]}, {31'd0, c == 3});
         tick();
      end
      bus_op(1, 3, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h1, "ram_kept");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
